// File: rtl/da_pkg.sv
// Shared types and constants for the distributed-arithmetic column accumulator.
package da_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } da_state_t;

   localparam int DA_KERNEL_H      = 7;
   localparam int DA_ACC_W_DEFAULT = 16;

endpackage

// File: rtl/lut_mul.sv
// Combinational DA lookup: weighted sum of one 7-tap bit-plane, as a signed 8-bit value.
module lut_mul
   import da_pkg::*;
#(
   parameter int           DATA_W   = 8,
   parameter logic [4:0]   WEIGHT_0 = 5'd1,
   parameter logic [4:0]   WEIGHT_1 = 5'd2,
   parameter logic [4:0]   WEIGHT_2 = 5'd3,
   parameter logic [4:0]   WEIGHT_3 = 5'd4,
   parameter logic [4:0]   WEIGHT_4 = 5'd5,
   parameter logic [4:0]   WEIGHT_5 = 5'd6,
   parameter logic [4:0]   WEIGHT_6 = 5'd7
) (
   input  logic        [DA_KERNEL_H-1:0] d,
   output logic signed [7:0]             sum
);

   localparam logic [4:0] W [DA_KERNEL_H] = '{WEIGHT_0, WEIGHT_1, WEIGHT_2, WEIGHT_3,
                                              WEIGHT_4, WEIGHT_5, WEIGHT_6};

   // A zero-width pixel has no planes, so the table collapses to zero.
   if (DATA_W > 0) begin : g_lut
      always_comb begin
         sum = '0;
         for (int k = 0; k < DA_KERNEL_H; k++)
            sum = sum + (d[k] ? $signed({3'b000, W[k]}) : 8'sd0);
      end
   end else begin : g_empty
      assign sum = '0;
   end

endmodule

// File: rtl/da_col_accum.sv
// Bit-serial DA column accumulator: feeds MSB-first bit-planes of a latched column
// through lut_mul and shift-accumulates the partial sums into the weighted column sum.
module da_col_accum
   import da_pkg::*;
#(
   parameter int         DATA_W   = 8,
   parameter int         KERNEL_H = DA_KERNEL_H,
   parameter logic [4:0] WEIGHT_0 = 5'd1,
   parameter logic [4:0] WEIGHT_1 = 5'd2,
   parameter logic [4:0] WEIGHT_2 = 5'd3,
   parameter logic [4:0] WEIGHT_3 = 5'd4,
   parameter logic [4:0] WEIGHT_4 = 5'd5,
   parameter logic [4:0] WEIGHT_5 = 5'd6,
   parameter logic [4:0] WEIGHT_6 = 5'd7,
   parameter int         ACC_W    = DA_ACC_W_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [KERNEL_H*DATA_W-1:0] in_pix,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [ACC_W-1:0]    out_sum
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   da_state_t                    state_q, state_d;
   logic [KERNEL_H*DATA_W-1:0]   col_q;
   logic signed [ACC_W-1:0]      acc_q;
   logic [CNT_W-1:0]             bitcnt_q;
   logic [DA_KERNEL_H-1:0]       plane;
   logic signed [7:0]            lut_sum;
   logic                         accept;

   // Bit-plane select: bit bitcnt of every tap.
   for (genvar k = 0; k < KERNEL_H; k++) begin : g_plane
      logic [DATA_W-1:0] pix_k;
      assign pix_k    = col_q[k*DATA_W +: DATA_W];
      assign plane[k] = pix_k[bitcnt_q];
   end

   lut_mul #(
      .DATA_W   (8),
      .WEIGHT_0 (WEIGHT_0),
      .WEIGHT_1 (WEIGHT_1),
      .WEIGHT_2 (WEIGHT_2),
      .WEIGHT_3 (WEIGHT_3),
      .WEIGHT_4 (WEIGHT_4),
      .WEIGHT_5 (WEIGHT_5),
      .WEIGHT_6 (WEIGHT_6)
   ) u_lut (
      .d   (plane),
      .sum (lut_sum)
   );

   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = SHIFT;
         end
         SHIFT: begin
            if (bitcnt_q == '0) state_d = DONE;
         end
         DONE: begin
            // Output and input handshakes may share one edge.
            in_ready = out_ready;
            if (out_ready) state_d = in_valid ? SHIFT : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rst) in_ready = 1'b0;
   end

   assign accept    = in_valid & in_ready;
   assign out_valid = (state_q == DONE) & ~rst;
   assign out_sum   = acc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         bitcnt_q <= '0;
         col_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            col_q    <= in_pix;
            acc_q    <= '0;
            bitcnt_q <= CNT_W'(DATA_W - 1);
         end else if (state_q == SHIFT) begin
            acc_q <= (acc_q <<< 1) + {{(ACC_W-8){lut_sum[7]}}, lut_sum};
            if (bitcnt_q != '0) bitcnt_q <= bitcnt_q - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_da_col_accum.sv
// Self-checking bench for da_col_accum: directed scenarios plus a randomized scoreboard run.
module tb_da_col_accum;

   localparam int DW = 8;
   localparam int KH = 7;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [KH*DW-1:0] in_pix;
   logic          out_valid;
   logic          out_ready;
   logic signed [AW-1:0] out_sum;

   int errors = 0;
   int checks = 0;

   da_col_accum dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pix    (in_pix),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum)
   );

   always #5 clk = ~clk;

   // Reference: plain weighted sum with weights 1..7, wrapped to AW bits.
   function automatic logic [AW-1:0] ref_sum(input logic [KH*DW-1:0] c);
      int s = 0;
      for (int k = 0; k < KH; k++) s += (k + 1) * int'(c[k*DW +: DW]);
      return AW'(s);
   endfunction

   function automatic logic [KH*DW-1:0] rep(input logic [DW-1:0] v);
      return {KH{v}};
   endfunction

   // Present a column and wait (bounded) for its handshake edge; returns at edge+#1.
   task automatic send_col(input logic [KH*DW-1:0] c, output bit ok);
      ok       = 1'b0;
      in_valid = 1'b1;
      in_pix   = c;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk); #1;
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   // Count negedges (edges after the handshake) until out_valid; -1 on timeout.
   task automatic wait_valid(output int n);
      n = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (out_valid) begin n = i; break; end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; in_pix = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_sum !== '0) begin errors++; $display("FAIL post_rst_out_sum got=%0d exp=0", out_sum); end
   endtask

   task automatic test_single(input string name, input logic [KH*DW-1:0] c, input logic [AW-1:0] exp);
      bit ok; int n;
      out_ready = 1'b1;
      send_col(c, ok);
      checks++; if (!ok) begin errors++; $display("FAIL %s_accept timeout", name); end
      wait_valid(n);
      // Handshake edge plus DW shift edges -> DW+1 cycles of latency.
      checks++; if (n + 1 != DW + 1) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", name, n + 1, DW + 1); end
      checks++; if (out_sum !== exp) begin errors++; $display("FAIL %s_sum got=%0d exp=%0d", name, out_sum, exp); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      bit ok; int n;
      out_ready = 1'b0;
      send_col(rep(8'd3), ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_accept timeout"); end
      wait_valid(n);
      checks++; if (n < 0) begin errors++; $display("FAIL bp_first_valid timeout"); end
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_sum !== 16'sd84 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d valid=%b sum=%0d in_ready=%b exp valid=1 sum=84 in_ready=0",
                     i, out_valid, out_sum, in_ready);
         end
      end
      in_valid = 1'b1; in_pix = rep(8'd4); out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
      @(posedge clk); #1 in_valid = 1'b0;
      wait_valid(n);
      checks++; if (n + 1 != DW + 1) begin errors++; $display("FAIL bp_next_latency got=%0d exp=%0d", n + 1, DW + 1); end
      checks++; if (out_sum !== 16'sd112) begin errors++; $display("FAIL bp_next_sum got=%0d exp=112", out_sum); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [AW-1:0] got [$];
      logic [AW-1:0] exp [4] = '{16'd28, 16'd56, 16'd84, 16'd112};
      out_ready = 1'b1;
      fork
         begin
            bit ok;
            for (int v = 1; v <= 4; v++) begin
               send_col(rep(DW'(v)), ok);
               if (!ok) break;
            end
         end
         begin
            for (int c = 0; c < 80; c++) begin
               @(negedge clk);
               if (out_valid && out_ready) got.push_back(out_sum);
            end
         end
      join
      checks++; if (got.size() != 4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         checks++; if (got[i] !== exp[i]) begin errors++; $display("FAIL b2b_sum[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
      end
   endtask

   task automatic test_reset_abort;
      bit ok; int n; int seen = 0;
      out_ready = 1'b1;
      send_col(rep(8'd5), ok);
      checks++; if (!ok) begin errors++; $display("FAIL abort_accept timeout"); end
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL abort_during_rst valid=%b in_ready=%b exp 0 0", out_valid, in_ready); end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_after_rst valid=%b in_ready=%b exp 0 1", out_valid, in_ready); end
      for (int i = 0; i < 20; i++) begin @(negedge clk); if (out_valid) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL abort_ghost_output got=%0d exp=0", seen); end
      send_col(rep(8'd2), ok);
      wait_valid(n);
      checks++; if (n < 0 || out_sum !== 16'sd56) begin errors++; $display("FAIL abort_next_sum got=%0d exp=56 wait=%0d", out_sum, n); end
      @(posedge clk); #1;
   endtask

   task automatic test_random;
      localparam int NCOL = 1000;
      logic [AW-1:0] q [$];
      int got = 0, bad = 0, hold_bad = 0;
      bit prod_done = 1'b0;
      fork
         begin
            bit ok;
            logic [KH*DW-1:0] c;
            for (int i = 0; i < NCOL; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #1;
               for (int k = 0; k < KH; k++) c[k*DW +: DW] = DW'($urandom);
               send_col(c, ok);
               if (!ok) break;
               q.push_back(ref_sum(c));
            end
            prod_done = 1'b1;
         end
         begin
            logic held = 1'b0;
            logic [AW-1:0] held_sum = '0;
            for (int cyc = 0; cyc < 40000 && got < NCOL; cyc++) begin
               @(posedge clk); #2;
               out_ready = ($urandom_range(0, 3) != 0);
               @(negedge clk);
               if (held && (!out_valid || out_sum !== held_sum)) hold_bad++;
               held = out_valid && !out_ready;
               held_sum = out_sum;
               if (out_valid && out_ready) begin
                  if (q.size() == 0 || out_sum !== q[0]) begin
                     bad++;
                     if (bad < 5) $display("FAIL rand_sum idx=%0d got=%0d exp=%0d", got, out_sum, q.size() ? q[0] : 'x);
                  end
                  if (q.size() != 0) void'(q.pop_front());
                  got++;
               end
            end
         end
      join
      checks++; if (got != NCOL) begin errors++; $display("FAIL rand_count got=%0d exp=%0d", got, NCOL); end
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_mismatches got=%0d exp=0", bad); end
      checks++; if (hold_bad != 0) begin errors++; $display("FAIL rand_hold_stable got=%0d exp=0", hold_bad); end
      checks++; if (!prod_done) begin errors++; $display("FAIL rand_producer_done got=0 exp=1"); end
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset;
      test_single("ones",   rep(8'd1), 16'd28);
      test_single("tap0",   {{(6*DW){1'b0}}, 8'd255}, 16'd255);
      test_single("tap6",   {8'd255, {(6*DW){1'b0}}}, 16'd1785);
      test_single("all255", rep(8'd255), 16'd7140);
      test_backpressure;
      test_back_to_back;
      test_reset_abort;
      test_random;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
